// File: rtl/scalar_rf_pkg.sv
// Shared constants for the scalar register file and its write-port logic.
//   SRF_ADDR_W / SRF_DATA_W / SRF_DEPTH : register file geometry
//   SRF_NUM_REQ                         : writeback requesters sharing the port
//   REQ_ALU / REQ_LD / REQ_VRED         : requester index assignment
//   idx_width()                         : index width for an N-way selector
package scalar_rf_pkg;

  localparam int SRF_ADDR_W  = 4;
  localparam int SRF_DATA_W  = 16;
  localparam int SRF_DEPTH   = 16;
  localparam int SRF_NUM_REQ = 3;

  localparam int REQ_ALU  = 0;
  localparam int REQ_LD   = 1;
  localparam int REQ_VRED = 2;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with last-grant state.
//   clk, rst_n : clock, asynchronous active-low reset
//   req_i      : per-requester request
//   grant_o    : one-hot grant (combinational), forced to 0 while in reset
// The search begins one past the last granted index, so after reset
// (last = N-1) requester 0 has first priority. Every grant is a transfer
// because only requesting inputs are granted, so last_q follows any grant.
module rr_arbiter
  import scalar_rf_pkg::*;
#(
  parameter int N = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req_i,
  output logic [N-1:0] grant_o
);

  localparam int IW = idx_width(N);
  localparam logic [IW-1:0] LAST_RST = IW'(N - 1);

  logic [IW-1:0] last_q, last_d;
  logic [IW-1:0] idx;
  logic          found;

  always_comb begin
    grant_o = '0;
    last_d  = last_q;
    found   = 1'b0;
    idx     = '0;
    for (int k = 1; k <= N; k++) begin
      idx = IW'((int'(last_q) + k) % N);
      if (rst_n && !found && req_i[idx]) begin
        found        = 1'b1;
        grant_o[idx] = 1'b1;
        last_d       = idx;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= LAST_RST;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/scalar_wb_arbiter.sv
// Write-port arbiter and hazard scoreboard for the scalar register file.
//   clk, rst_n              : clock, asynchronous active-low reset
//   req_valid/dst/data      : NUM_REQ writeback requesters, packed per index
//   req_ready               : one-hot grant; transfer on valid & ready
//   rf_wr_en/dst/data       : registered register-file write port
//   issue_en, issue_dst     : decode marks issue_dst as in flight
//   chk_addr_*, chk_use_*   : source operands of the instruction in decode
//   stall                   : combinational hazard indication
//   pending                 : scoreboard bits (debug)
// A pending bit clears on the edge that ends the rf_wr_en cycle for its
// register, so a same-register check during that cycle still stalls and
// a same-cycle issue of the retiring register keeps the bit set.
module scalar_wb_arbiter
  import scalar_rf_pkg::*;
#(
  parameter int NUM_REQ = SRF_NUM_REQ,
  parameter int DATA_W  = SRF_DATA_W,
  parameter int ADDR_W  = SRF_ADDR_W
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] req_dst,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      rf_wr_en,
  output logic [ADDR_W-1:0]         rf_wr_dst,
  output logic [DATA_W-1:0]         rf_wr_data,
  input  logic                      issue_en,
  input  logic [ADDR_W-1:0]         issue_dst,
  input  logic [ADDR_W-1:0]         chk_addr_1,
  input  logic [ADDR_W-1:0]         chk_addr_2,
  input  logic                      chk_use_1,
  input  logic                      chk_use_2,
  output logic                      stall,
  output logic [(1<<ADDR_W)-1:0]    pending
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [NUM_REQ-1:0] grant;
  logic               transfer;
  logic [ADDR_W-1:0]  sel_dst;
  logic [DATA_W-1:0]  sel_data;

  logic               wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]  wr_dst_q, wr_dst_d;
  logic [DATA_W-1:0]  wr_data_q, wr_data_d;
  logic [DEPTH-1:0]   pending_q, pending_d;

  rr_arbiter #(
    .N(NUM_REQ)
  ) u_rr (
    .clk    (clk),
    .rst_n  (rst_n),
    .req_i  (req_valid),
    .grant_o(grant)
  );

  assign req_ready = grant;
  assign transfer  = |grant;

  always_comb begin
    sel_dst  = '0;
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        sel_dst  = req_dst[i*ADDR_W +: ADDR_W];
        sel_data = req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    wr_en_d   = transfer;
    wr_dst_d  = wr_dst_q;
    wr_data_d = wr_data_q;
    if (transfer) begin
      wr_dst_d  = sel_dst;
      wr_data_d = sel_data;
    end
  end

  // Retire first, then issue, so set wins on the same register.
  always_comb begin
    pending_d = pending_q;
    if (wr_en_q) begin
      pending_d[wr_dst_q] = 1'b0;
    end
    if (issue_en) begin
      pending_d[issue_dst] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_en_q   <= 1'b0;
      wr_dst_q  <= '0;
      wr_data_q <= '0;
      pending_q <= '0;
    end else begin
      wr_en_q   <= wr_en_d;
      wr_dst_q  <= wr_dst_d;
      wr_data_q <= wr_data_d;
      pending_q <= pending_d;
    end
  end

  assign stall = (chk_use_1 & pending_q[chk_addr_1])
               | (chk_use_2 & pending_q[chk_addr_2])
               | (issue_en  & pending_q[issue_dst]);

  assign rf_wr_en   = wr_en_q;
  assign rf_wr_dst  = wr_dst_q;
  assign rf_wr_data = wr_data_q;
  assign pending    = pending_q;

endmodule

// File: tb/tb_scalar_wb_arbiter.sv
module tb_scalar_wb_arbiter;

  localparam int N  = 3;
  localparam int AW = 4;
  localparam int DW = 16;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req_valid;
  logic [N*AW-1:0] req_dst;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_ready;
  logic            rf_wr_en;
  logic [AW-1:0]   rf_wr_dst;
  logic [DW-1:0]   rf_wr_data;
  logic            issue_en;
  logic [AW-1:0]   issue_dst;
  logic [AW-1:0]   chk_addr_1, chk_addr_2;
  logic            chk_use_1, chk_use_2;
  logic            stall;
  logic [15:0]     pending;

  scalar_wb_arbiter #(.NUM_REQ(N), .DATA_W(DW), .ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_dst(req_dst), .req_data(req_data),
    .req_ready(req_ready),
    .rf_wr_en(rf_wr_en), .rf_wr_dst(rf_wr_dst), .rf_wr_data(rf_wr_data),
    .issue_en(issue_en), .issue_dst(issue_dst),
    .chk_addr_1(chk_addr_1), .chk_addr_2(chk_addr_2),
    .chk_use_1(chk_use_1), .chk_use_2(chk_use_2),
    .stall(stall), .pending(pending)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Requester-side stimulus state
  bit            rv [N];
  logic [AW-1:0] rd [N];
  logic [DW-1:0] rx [N];
  bit            keep;
  bit            rand_mode;

  // Reference model
  int            m_lg;
  bit [15:0]     m_pend;
  bit            m_en;
  logic [AW-1:0] m_dst;
  logic [DW-1:0] m_data;
  int            seen_grant;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      req_valid[i]          = rv[i];
      req_dst[i*AW +: AW]   = rd[i];
      req_data[i*DW +: DW]  = rx[i];
    end
  endtask

  function automatic int model_grant();
    for (int k = 1; k <= N; k++) begin
      if (rv[(m_lg + k) % N]) return (m_lg + k) % N;
    end
    return -1;
  endfunction

  function automatic bit model_stall();
    return (chk_use_1 && m_pend[chk_addr_1]) || (chk_use_2 && m_pend[chk_addr_2]) ||
           (issue_en && m_pend[issue_dst]);
  endfunction

  task automatic clear_all();
    m_lg = N - 1; m_pend = '0; m_en = 0; m_dst = '0; m_data = '0;
    for (int i = 0; i < N; i++) begin rv[i] = 0; rd[i] = '0; rx[i] = '0; end
    keep = 0;
    issue_en = 0; issue_dst = '0;
    chk_addr_1 = '0; chk_addr_2 = '0; chk_use_1 = 0; chk_use_2 = 0;
    drive();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_all();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Starts at a negedge with inputs set; compares, steps one edge, ends at a negedge.
  task automatic cycle();
    int g;
    logic [N-1:0] exp_ready;
    drive();
    #1;
    g = model_grant();
    exp_ready = (g >= 0) ? N'(1 << g) : '0;
    check_val("ready", 32'(req_ready), 32'(exp_ready));
    check_val("stall", 32'(stall), 32'(model_stall()));
    check_val("wr_en", 32'(rf_wr_en), 32'(m_en));
    check_val("wr_dst", 32'(rf_wr_dst), 32'(m_dst));
    check_val("wr_data", 32'(rf_wr_data), 32'(m_data));
    check_val("pending", 32'(pending), 32'(m_pend));
    seen_grant = g;
    @(posedge clk);
    if (m_en) m_pend[m_dst] = 1'b0;
    if (issue_en) m_pend[issue_dst] = 1'b1;
    if (g >= 0) begin
      m_lg = g; m_en = 1; m_dst = rd[g]; m_data = rx[g];
      if (rand_mode) begin
        rv[g] = 1'($urandom_range(0, 1));
        rd[g] = AW'($urandom); rx[g] = DW'($urandom);
      end else if (!keep) begin
        rv[g] = 0;
      end
    end else begin
      m_en = 0;
    end
    if (rand_mode) begin
      for (int i = 0; i < N; i++) begin
        if (!rv[i] && $urandom_range(0, 2) == 0) begin
          rv[i] = 1; rd[i] = AW'($urandom); rx[i] = DW'($urandom);
        end
      end
    end
    @(negedge clk);
  endtask

  int order [6];
  int exp_order [6] = '{0, 1, 2, 0, 1, 2};

  initial begin
    rand_mode = 0;
    do_reset();

    // Reset values
    drive(); #1;
    check_val("rst_wr_en", 32'(rf_wr_en), 32'h0);
    check_val("rst_pending", 32'(pending), 32'h0);
    check_val("rst_stall", 32'(stall), 32'h0);
    check_val("rst_ready", 32'(req_ready), 32'h0);
    cycle();

    // Single requester 1
    rv[1] = 1; rd[1] = 4'h5; rx[1] = 16'hBEEF;
    drive(); #1;
    check_val("single_ready", 32'(req_ready), 32'b010);
    cycle();
    check_val("single_wr_en", 32'(rf_wr_en), 32'h1);
    check_val("single_dst", 32'(rf_wr_dst), 32'h5);
    check_val("single_data", 32'(rf_wr_data), 32'hBEEF);
    cycle();
    check_val("single_wr_en_off", 32'(rf_wr_en), 32'h0);

    // All three continuously for six cycles, from fresh priority
    do_reset();
    keep = 1;
    for (int i = 0; i < N; i++) begin rv[i] = 1; rd[i] = AW'(8 + i); rx[i] = DW'(16'h1000 * (i + 1)); end
    for (int c = 0; c < 6; c++) begin
      drive(); #1;
      check_val("full_onehot", 32'($countones(req_ready)), 32'h1);
      cycle();
      order[c] = seen_grant;
      check_val("full_wr_en", 32'(rf_wr_en), 32'h1);
    end
    for (int c = 0; c < 6; c++) check_val("full_order", 32'(order[c]), 32'(exp_order[c]));
    keep = 0;
    repeat (4) cycle();

    // Scoreboard on R3
    issue_en = 1; issue_dst = 4'h3;
    cycle();
    issue_en = 0; chk_addr_1 = 4'h3; chk_use_1 = 1;
    drive(); #1;
    check_val("sb_stall_issue", 32'(stall), 32'h1);
    cycle();
    rv[0] = 1; rd[0] = 4'h3; rx[0] = 16'h3333;
    cycle();
    check_val("sb_stall_wr_cycle", 32'(stall), 32'h1);
    cycle();
    check_val("sb_stall_clear", 32'(stall), 32'h0);
    check_val("sb_pend3", 32'(pending[3]), 32'h0);
    chk_use_1 = 0;
    cycle();

    // Same-cycle retire and issue of R7
    issue_en = 1; issue_dst = 4'h7;
    cycle();
    issue_en = 0;
    rv[0] = 1; rd[0] = 4'h7; rx[0] = 16'h7777;
    cycle();
    issue_en = 1; issue_dst = 4'h7;
    cycle();
    issue_en = 0; chk_addr_1 = 4'h7; chk_use_1 = 0;
    drive(); #1;
    check_val("r7_pend", 32'(pending[7]), 32'h1);
    check_val("r7_stall_unused", 32'(stall), 32'h0);
    cycle();

    // Build pending = 16'h00F0, then async reset during a grant
    for (int r = 4; r < 7; r++) begin
      issue_en = 1; issue_dst = AW'(r);
      cycle();
    end
    issue_en = 0;
    check_val("pre_rst_pending", 32'(pending), 32'h00F0);
    rv[1] = 1; rd[1] = 4'h1; rx[1] = 16'hAAAA;
    rv[2] = 1; rd[2] = 4'h2; rx[2] = 16'h5555;
    cycle();
    drive(); #1;
    check_val("pre_rst_ready", 32'(req_ready), 32'b100);
    check_val("pre_rst_wr_en", 32'(rf_wr_en), 32'h1);
    #1 rst_n = 1'b0;
    #1;
    check_val("arst_wr_en", 32'(rf_wr_en), 32'h0);
    check_val("arst_dst", 32'(rf_wr_dst), 32'h0);
    check_val("arst_data", 32'(rf_wr_data), 32'h0);
    check_val("arst_pending", 32'(pending), 32'h0);
    check_val("arst_ready", 32'(req_ready), 32'h0);
    check_val("arst_stall", 32'(stall), 32'h0);
    clear_all();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < N; i++) begin rv[i] = 1; rd[i] = AW'(i); rx[i] = DW'($urandom); end
    drive(); #1;
    check_val("post_rst_prio", 32'(req_ready), 32'b001);
    repeat (4) cycle();

    // Randomized traffic against the model
    rand_mode = 1;
    for (int c = 0; c < 400; c++) begin
      issue_en   = ($urandom_range(0, 3) == 0);
      issue_dst  = AW'($urandom);
      chk_addr_1 = AW'($urandom);
      chk_addr_2 = AW'($urandom);
      chk_use_1  = 1'($urandom_range(0, 1));
      chk_use_2  = 1'($urandom_range(0, 1));
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
